// File: rtl/data_mem_access_unit.sv
// Load/store unit between the core and a word-wide data memory: byte/half/word
// access with read-modify-write sub-word stores. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module data_mem_access_unit #(
  parameter int DEPTH = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqStore,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRData,
  output logic        RspErr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWen,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      st, st_nxt;
  logic        store_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;

  logic        accept, f3_bad, oob, is_half, is_word, req_err;
  logic [31:0] addr_al, ld_val, merged;
  logic [31:0] b_sh, h_sh;
  logic [4:0]  sh_b, sh_h;

  assign accept  = ReqValid && ReqReady;
  assign is_half = (ReqFunct3[1:0] == 2'd1);
  assign is_word = (ReqFunct3[1:0] == 2'd2);
  assign f3_bad  = ReqStore ? (ReqFunct3 > 3'd2)
                            : ((ReqFunct3 == 3'd3) || (ReqFunct3 >= 3'd6));
  assign oob     = ({2'b00, ReqAddr[31:2]} >= 32'(DEPTH));

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis     = (is_half && ReqAddr[0]) || (is_word && (ReqAddr[1:0] != 2'b00));
  assign req_err = f3_bad || oob || mis;
  assign addr_al = ReqAddr;
`else
  // Misaligned sub-word addresses are silently rounded down to the natural boundary.
  assign req_err = f3_bad || oob;
  assign addr_al = is_word ? {ReqAddr[31:2], 2'b00} :
                   is_half ? {ReqAddr[31:1], 1'b0}  : ReqAddr;
`endif

  // Lane extraction for loads, taken straight from the memory read word.
  assign sh_b = {addr_q[1:0], 3'b000};
  assign sh_h = {addr_q[1], 4'b0000};
  assign b_sh = MemRData >> sh_b;
  assign h_sh = MemRData >> sh_h;

  always_comb begin
    ld_val = 32'd0;
    case (f3_q)
      3'd0:    ld_val = {{24{b_sh[7]}}, b_sh[7:0]};
      3'd1:    ld_val = {{16{h_sh[15]}}, h_sh[15:0]};
      3'd2:    ld_val = MemRData;
      3'd4:    ld_val = {24'd0, b_sh[7:0]};
      3'd5:    ld_val = {16'd0, h_sh[15:0]};
      default: ld_val = 32'd0;
    endcase
  end

  // Sub-word store: splice the new lane into the word captured during READ.
  always_comb begin
    merged = word_q;
    if (f3_q[1:0] == 2'd0)
      merged = (word_q & ~(32'h0000_00FF << sh_b)) | ({24'd0, wdata_q[7:0]} << sh_b);
    else if (f3_q[1:0] == 2'd1)
      merged = (word_q & ~(32'h0000_FFFF << sh_h)) | ({16'd0, wdata_q[15:0]} << sh_h);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (accept) begin
          if (req_err)        st_nxt = RESP;
          else if (!ReqStore) st_nxt = READ;
          else if (is_word)   st_nxt = WRITE;
          else                st_nxt = READ;
        end
      end
      READ:    st_nxt = store_q ? WRITE : RESP;
      WRITE:   st_nxt = RESP;
      RESP:    if (RspReady) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    ReqReady = (st == IDLE);
    RspValid = (st == RESP);
    RspRData = 32'd0;
    RspErr   = 1'b0;
    MemAddr  = 32'd0;
    MemWData = 32'd0;
    MemWen   = 1'b0;
    case (st)
      READ:  MemAddr = {2'b00, addr_q[31:2]};
      WRITE: begin
        MemAddr  = {2'b00, addr_q[31:2]};
        MemWData = (f3_q[1:0] == 2'd2) ? wdata_q : merged;
        MemWen   = 1'b1;
      end
      RESP: begin
        RspRData = rdata_q;
        RspErr   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      store_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        store_q <= ReqStore;
        err_q   <= req_err;
        f3_q    <= ReqFunct3;
        addr_q  <= addr_al;
        wdata_q <= ReqWData;
        rdata_q <= 32'd0;
      end
      if (st == READ) begin
        word_q <= MemRData;
        if (!store_q) rdata_q <= ld_val;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a behavioural 32-word memory.
module tb_data_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        ReqValid = 1'b0, ReqStore = 1'b0, RspReady = 1'b0;
  logic [2:0]  ReqFunct3 = 3'd0;
  logic [31:0] ReqAddr = 32'd0, ReqWData = 32'd0;
  logic        ReqReady, RspValid, RspErr, MemWen;
  logic [31:0] RspRData, MemAddr, MemWData, MemRData;

  logic [31:0] mem [32];
  int          checks = 0, errors = 0;
  int          wen_cnt = 0;
  logic [31:0] waddr = 32'd0;

  always #5 Clk = ~Clk;

  data_mem_access_unit #(.DEPTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqStore(ReqStore), .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspReady(RspReady), .RspRData(RspRData), .RspErr(RspErr),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWen(MemWen), .MemRData(MemRData)
  );

  assign MemRData = (MemAddr < 32'd32) ? mem[MemAddr[4:0]] : 32'd0;

  always @(posedge Clk)
    if (MemWen && MemAddr < 32'd32) mem[MemAddr[4:0]] <= MemWData;

  always @(negedge Clk)
    if (MemWen) begin
      wen_cnt <= wen_cnt + 1;
      waddr   <= MemAddr;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; returns accept-to-RspValid latency, data and error.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er);
    @(negedge Clk);
    wen_cnt = 0;
    ReqValid = 1'b1; ReqStore = st; ReqFunct3 = f3; ReqAddr = a; ReqWData = wd;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    lat = 1;
    while (!RspValid && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    rd = RspRData; er = RspErr;
    RspReady = 1'b1;
    @(posedge Clk); #1;
    RspReady = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd, hold_rd;
  logic        er;

  initial begin
    // Reset state
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_rspvalid", {31'd0, RspValid}, 32'd0);
    chk("rst_memwen",   {31'd0, MemWen},   32'd0);
    chk("rst_memaddr",  MemAddr,  32'd0);
    chk("rst_memwdata", MemWData, 32'd0);
    chk("rst_rdata",    RspRData, 32'd0);
    chk("rst_err",      {31'd0, RspErr},   32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_reqready", {31'd0, ReqReady}, 32'd1);

    // SW then LW
    access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, rd, er);
    chk("sw_lat",   lat, 2);
    chk("sw_wen",   wen_cnt, 1);
    chk("sw_waddr", waddr, 32'd4);
    chk("sw_err",   {31'd0, er}, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    access(1'b0, 3'd2, 32'h10, 32'd0, lat, rd, er);
    chk("lw_lat",   lat, 2);
    chk("lw_data",  rd, 32'hDEADBEEF);
    chk("lw_err",   {31'd0, er}, 32'd0);
    chk("lw_nowen", wen_cnt, 0);

    // SB on a known word, then byte loads
    access(1'b1, 3'd2, 32'h10, 32'h12345678, lat, rd, er);
    access(1'b1, 3'd0, 32'h11, 32'h000000AB, lat, rd, er);
    chk("sb_lat", lat, 3);
    chk("sb_wen", wen_cnt, 1);
    access(1'b0, 3'd2, 32'h10, 32'd0, lat, rd, er);
    chk("sb_word", rd, 32'h1234AB78);
    access(1'b0, 3'd0, 32'h11, 32'd0, lat, rd, er);
    chk("lb_data", rd, 32'hFFFFFFAB);
    access(1'b0, 3'd4, 32'h11, 32'd0, lat, rd, er);
    chk("lbu_data", rd, 32'h000000AB);

    // SH upper half, then halfword load
    access(1'b1, 3'd1, 32'h12, 32'h00008001, lat, rd, er);
    chk("sh_lat", lat, 3);
    access(1'b0, 3'd2, 32'h10, 32'd0, lat, rd, er);
    chk("sh_word", rd, 32'h8001AB78);
    access(1'b0, 3'd1, 32'h12, 32'd0, lat, rd, er);
    chk("lh_data", rd, 32'hFFFF8001);
    access(1'b0, 3'd5, 32'h12, 32'd0, lat, rd, er);
    chk("lhu_data", rd, 32'h00008001);

    // Errors: out of range, illegal funct3
    access(1'b0, 3'd2, 32'h80, 32'd0, lat, rd, er);
    chk("oob_err",  {31'd0, er}, 32'd1);
    chk("oob_lat",  lat, 1);
    chk("oob_wen",  wen_cnt, 0);
    chk("oob_data", rd, 32'd0);
    access(1'b0, 3'd3, 32'h10, 32'd0, lat, rd, er);
    chk("f3_err", {31'd0, er}, 32'd1);
    chk("f3_lat", lat, 1);
    access(1'b1, 3'd4, 32'h10, 32'h55, lat, rd, er);
    chk("sf3_err", {31'd0, er}, 32'd1);
    chk("sf3_wen", wen_cnt, 0);

    // Misaligned halfword
    access(1'b0, 3'd1, 32'h13, 32'd0, lat, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_lat", lat, 1);
`else
    chk("mis_err",  {31'd0, er}, 32'd0);
    chk("mis_data", rd, 32'hFFFF8001);
`endif

    // Response held while RspReady stays low
    @(negedge Clk);
    ReqValid = 1'b1; ReqStore = 1'b0; ReqFunct3 = 3'd2; ReqAddr = 32'h10;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    lat = 1;
    while (!RspValid && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("hold_lat", lat, 2);
    hold_rd = RspRData;
    chk("hold_data0", hold_rd, 32'h8001AB78);
    ReqValid = 1'b1; ReqAddr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("hold_valid", {31'd0, RspValid}, 32'd1);
      chk("hold_data",  RspRData, 32'h8001AB78);
      chk("hold_rdy",   {31'd0, ReqReady}, 32'd0);
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    chk("hold_idle", {31'd0, ReqReady}, 32'd1);

    // Reset asserted during WRITE of an SB
    wen_cnt = 0;
    ReqValid = 1'b1; ReqStore = 1'b1; ReqFunct3 = 3'd0; ReqAddr = 32'h14; ReqWData = 32'h5A;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rw_in_write", {31'd0, MemWen}, 32'd1);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rw_rspvalid", {31'd0, RspValid}, 32'd0);
    chk("rw_memwen",   {31'd0, MemWen},   32'd0);
    chk("rw_memaddr",  MemAddr,  32'd0);
    chk("rw_memwdata", MemWData, 32'd0);
    chk("rw_reqready", {31'd0, ReqReady}, 32'd1);
    Rst = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      chk("rw_norsp", {31'd0, RspValid}, 32'd0);
    end
    chk("rw_wen_cnt", {31'd0, (wen_cnt <= 1)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
DATA_MEM_ACCESS_UNIT -- requirements
Module: data_mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port Clk, input, 1: clock; all state updates on posedge.
REQ-003 SHALL have port Rst, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port ReqValid, input, 1: core presents an access.
REQ-005 SHALL have port ReqReady, output, 1: unit accepts a request; high only in IDLE.
REQ-006 SHALL have port ReqStore, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port ReqFunct3, input, 3: RISC-V funct3; LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
REQ-008 SHALL have port ReqAddr, input, 32: byte address.
REQ-009 SHALL have port ReqWData, input, 32: store data, right-aligned.
REQ-010 SHALL have port RspValid, output, 1: response available.
REQ-011 SHALL have port RspReady, input, 1: core consumes the response.
REQ-012 SHALL have port RspRData, output, 32: load result, sign/zero-extended; 0 for stores and errors.
REQ-013 SHALL have port RspErr, output, 1: the access was rejected.
REQ-014 SHALL have port MemAddr, output, 32: word index (ReqAddr[31:2]) to memory.
REQ-015 SHALL have port MemWData, output, 32: word written to memory.
REQ-016 SHALL have port MemWen, output, 1: memory write enable; memory writes on the same posedge.
REQ-017 SHALL have port MemRData, input, 32: memory read word, combinational from MemAddr.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE, and RESP.
REQ-019 SHALL accept a request on the posedge where ReqValid and ReqReady are both 1, registering funct3, the address, the data, and the store bit.
REQ-020 SHALL detect these errors at accept:
- illegal funct3: loads 3/6/7, stores 3-7;
- word index >= DEPTH;
- misalignment, when enabled per REQ-033.
REQ-021 On an error, the FSM SHALL go IDLE->RESP with RspErr=1, and SHALL drive no MemWen.
REQ-022 For a load, the FSM SHALL go IDLE->READ.
- In READ, MemAddr = registered word index.
- MemRData is sampled, then the selected byte/half/word is extracted using addr[1:0] and extended per funct3.
- Next state is RESP.
REQ-023 For SW, the FSM SHALL go IDLE->WRITE, with MemWData=ReqWData and MemWen=1 for exactly one cycle, then RESP.
REQ-024 For SB/SH, the FSM SHALL go IDLE->READ->WRITE.
- READ captures MemRData.
- WRITE drives the captured word with the lane selected by addr[1:0] replaced by ReqWData[7:0] or [15:0]; other bytes are unchanged.
- MemWen=1 for one cycle, then RESP.
REQ-025 Latency from accept to RspValid SHALL be:
- load 2 cycles;
- SW 2 cycles;
- SB/SH 3 cycles;
- error 1 cycle.
REQ-026 RSP SHALL hold RspValid, RspRData, and RspErr stable until RspReady=1, then return to IDLE on that edge.
- ReqReady rises the following cycle; there is no back-to-back accept.
REQ-027 MemWen SHALL be 1 only in WRITE, and MemAddr/MemWData SHALL be 0 in IDLE and RESP.
REQ-028 ReqValid, ReqAddr, and the other request inputs SHALL be ignored outside IDLE.

Reset
REQ-029 While Rst=0 at posedge, the FSM SHALL enter IDLE with RspValid=0, RspErr=0, RspRData=0, MemWen=0, MemAddr=0, and MemWData=0; ReqReady SHALL be 1 on the first cycle after Rst rises.
REQ-030 Reset in READ or WRITE SHALL abandon the access with no further MemWen and no response.
- A write already committed on the same edge is allowed.
REQ-031 Reset SHALL take priority over any simultaneous ReqValid or RspReady.

Configuration
REQ-032 SHALL provide the macro LSU_MISALIGN_TRAP_EN to compile the misalignment check in or out.
REQ-033 With LSU_MISALIGN_TRAP_EN defined, halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL be an error per REQ-021.
REQ-034 Without LSU_MISALIGN_TRAP_EN, the unit SHALL force the address aligned (halfword clears bit 0, word clears bits 1:0), never flag misalignment, and leave all other behaviour identical.

Verification
REQ-035 The bench SHALL cover SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> MemWen one cycle with MemAddr=4; load RspRData=0xDEADBEEF, RspErr=0.
REQ-036 The bench SHALL cover word 0x10=0x12345678, then SB addr 0x11, data 0xAB -> memory 0x1234AB78; a following LB 0x11 returns 0xFFFFFFAB and LBU 0x11 returns 0x000000AB.
REQ-037 The bench SHALL cover SH addr 0x12, data 0x8001 on 0x1234AB78 -> memory 0x8001AB78; LH 0x12 returns 0xFFFF8001.
REQ-038 The bench SHALL cover LW addr 0x80 (index 32, DEPTH=32) and load funct3=3 -> RspErr=1 after 1 cycle, no MemWen.
REQ-039 The bench SHALL cover LH addr 0x13:
- with the macro -> RspErr=1;
- without the macro -> data from addr 0x12, RspErr=0.
REQ-040 The bench SHALL cover RspReady held 0 for 5 cycles, then Rst=0 asserted during WRITE of an SB.
- Held RspReady -> response stable; ReqReady=0.
- Reset mid-WRITE -> next cycle IDLE, outputs zero, no response.
